bt_uart_decoder: RTL and testbench

Bluetooth command front end: receives 8N1 UART bytes from the HC-05-style Bluetooth module on `get_bluetooth`, validates the framing, and decodes command bytes into the `dir` and `state_choice` levels consumed by the game controller and play screen. It sits directly upstream of `controller` and `play_screen` in `top`, replacing the bare serial pin with registered, glitch-free control outputs.

---
 rtl/bt_pkg.sv | 20 ++
 rtl/bt_uart_decoder_if.sv | 12 +
 rtl/bt_uart_decoder_rx.sv | 99 +++++++++
 rtl/bt_uart_decoder.sv | 52 +++++
 tb/tb_bt_uart_decoder.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bt_pkg.sv
// bt_pkg: shared command bytes, output codes and receiver state encodings
package bt_pkg;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_Q = 8'h51;
    localparam logic [7:0] CMD_C = 8'h43;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

    // must match the codes the controller expects
    localparam logic [2:0] SC_NONE  = 3'b000;
    localparam logic [2:0] SC_START = 3'b010;
    localparam logic [2:0] SC_QUIT  = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_t;
endpackage

// File: rtl/bt_uart_decoder_if.sv
// bt_uart_decoder_if: serial input and decoded command outputs of the Bluetooth front end
interface bt_uart_decoder_if;
    logic       get_bluetooth;
    logic [1:0] dir;
    logic [2:0] state_choice;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    modport master (output get_bluetooth, input dir, state_choice, byte_valid, rx_byte, frame_err);
    modport slave  (input get_bluetooth, output dir, state_choice, byte_valid, rx_byte, frame_err);
endinterface

// File: rtl/bt_uart_decoder_rx.sv
// uart_rx_core: 8N1 receiver with input synchronizer, 16x oversample divider and framing check
module uart_rx_core #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       commit,
    output logic [7:0] data
);
    import bt_pkg::*;

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = $clog2(DIV + 1);

    logic          rx_m, rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    rx_state_t     state;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          armed;

    assign tick   = div_cnt == DW'(DIV - 1);
    // commit strobe lets the decoder update on the same edge as the stop-bit sample
    assign commit = state == ST_STOP && tick && tick_cnt == 4'd15 && rx_s;
    assign data   = shift;

    // two-flop synchronizer; resets low so a held-low line never looks idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {rx_s, rx_m} <= 2'b00;
        else      {rx_s, rx_m} <= {rx_m, rx};
    end

    // free-running oversample divider, never realigned to the start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_cnt <= '0;
        else      div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end

    // frame FSM: start validation at mid-bit, LSB-first data, stop-bit check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            armed      <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_s) armed <= 1'b1;
            case (state)
                ST_IDLE: if (armed && !rx_s) begin
                    state    <= ST_START;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                end
                ST_START: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd7) begin
                        tick_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                    end
                end
                ST_STOP: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        state <= ST_IDLE;
                        if (rx_s) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/bt_uart_decoder.sv
// bt_uart_decoder: decodes Bluetooth UART command bytes into dir and state_choice levels
module bt_uart_decoder #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int HOLD_CYCLES = 20_000_000
) (
    input logic               clk,
    input logic               rst,
    bt_uart_decoder_if.slave  bus
);
    import bt_pkg::*;

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic          commit;
    logic [7:0]    data;
    logic [HW-1:0] hold;
    logic          is_move;

    assign is_move = commit && (data == CMD_L || data == CMD_R);

    uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_core (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.get_bluetooth),
        .rx_byte    (bus.rx_byte),
        .byte_valid (bus.byte_valid),
        .frame_err  (bus.frame_err),
        .commit     (commit),
        .data       (data)
    );

    // command decode; a move byte in the expiry cycle wins over the timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dir          <= DIR_NONE;
            bus.state_choice <= SC_NONE;
            hold             <= '0;
        end else begin
            if (is_move) begin
                bus.dir <= data == CMD_L ? DIR_LEFT : DIR_RIGHT;
                hold    <= HW'(HOLD_CYCLES);
            end else begin
                hold <= hold != '0 ? hold - HW'(1) : hold;
                if ((commit && data == CMD_N) || hold == HW'(1)) bus.dir <= DIR_NONE;
            end
            if (commit && data == CMD_S)      bus.state_choice <= SC_START;
            else if (commit && data == CMD_Q) bus.state_choice <= SC_QUIT;
            else if (commit && data == CMD_C) bus.state_choice <= SC_NONE;
        end
    end
endmodule

// File: tb/tb_bt_uart_decoder.sv
// tb_bt_uart_decoder: directed scenarios for the Bluetooth UART command decoder
module tb_bt_uart_decoder;
    import bt_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bt_uart_decoder_if bus ();

    bt_uart_decoder #(.CLK_HZ(1_600_000), .BAUD(10_000), .HOLD_CYCLES(5000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   bv_cnt = 0;
    int   fe_cnt = 0;
    int   last_commit = 0;
    int   r_gap = 0;
    logic watch_r = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // pulse counters and continuity watch, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.byte_valid) begin
            bv_cnt++;
            last_commit = cyc;
        end
        if (bus.frame_err) fe_cnt++;
        if (watch_r && bus.dir !== 2'b10) r_gap++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        bus.get_bluetooth = 1'b1;
        repeat (40) @(negedge clk);
        bus.get_bluetooth = 1'b0;
        repeat (160) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.get_bluetooth = b[i];
            repeat (160) @(negedge clk);
        end
        bus.get_bluetooth = stop_ok;
        repeat (160) @(negedge clk);
        bus.get_bluetooth = 1'b1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.get_bluetooth = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.dir !== 2'b00 || bus.state_choice !== 3'b000) begin
            errors++;
            $display("FAIL reset_levels: dir=%b sc=%b expected 00/000", bus.dir, bus.state_choice);
        end
        vectors++;
        if (bus.byte_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx: bv=%b fe=%b rx=%h expected 0/0/00", bus.byte_valid, bus.frame_err, bus.rx_byte);
        end
        rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_left();
        int b0 = bv_cnt;
        send_byte(8'h4C, 1'b1);
        vectors++;
        if (bv_cnt - b0 !== 1) begin
            errors++;
            $display("FAIL left_pulses: got %0d expected 1", bv_cnt - b0);
        end
        vectors++;
        if (bus.rx_byte !== 8'h4C) begin
            errors++;
            $display("FAIL left_byte: got %h expected 4c", bus.rx_byte);
        end
        vectors++;
        if (bus.dir !== 2'b01) begin
            errors++;
            $display("FAIL left_dir: got %b expected 01", bus.dir);
        end
        wait_to(last_commit + 4999);
        vectors++;
        if (bus.dir !== 2'b01) begin
            errors++;
            $display("FAIL left_hold_last: got %b expected 01", bus.dir);
        end
        @(negedge clk);
        vectors++;
        if (bus.dir !== 2'b00) begin
            errors++;
            $display("FAIL left_expire: got %b expected 00", bus.dir);
        end
    endtask

    task automatic test_menu();
        int b0 = bv_cnt;
        send_byte(8'h53, 1'b1);
        vectors++;
        if (bus.state_choice !== 3'b010) begin
            errors++;
            $display("FAIL menu_start: got %b expected 010", bus.state_choice);
        end
        send_byte(8'h78, 1'b1);
        vectors++;
        if (bus.state_choice !== 3'b010 || bus.rx_byte !== 8'h78) begin
            errors++;
            $display("FAIL menu_other: sc=%b rx=%h expected 010/78", bus.state_choice, bus.rx_byte);
        end
        send_byte(8'h43, 1'b1);
        vectors++;
        if (bus.state_choice !== 3'b000) begin
            errors++;
            $display("FAIL menu_clear: got %b expected 000", bus.state_choice);
        end
        vectors++;
        if (bus.dir !== 2'b00 || bv_cnt - b0 !== 3) begin
            errors++;
            $display("FAIL menu_dir_count: dir=%b pulses=%0d expected 00/3", bus.dir, bv_cnt - b0);
        end
    endtask

    task automatic test_back_to_back_r();
        int c1, c2;
        int b0 = bv_cnt;
        send_byte(8'h52, 1'b1);
        c1 = last_commit;
        vectors++;
        if (bus.dir !== 2'b10) begin
            errors++;
            $display("FAIL r1_dir: got %b expected 10", bus.dir);
        end
        r_gap = 0;
        watch_r = 1'b1;
        wait_to(c1 + 1478);
        send_byte(8'h52, 1'b1);
        c2 = last_commit;
        vectors++;
        if (bv_cnt - b0 !== 2) begin
            errors++;
            $display("FAIL r2_pulses: got %0d expected 2", bv_cnt - b0);
        end
        wait_to(c2 + 4999);
        watch_r = 1'b0;
        vectors++;
        if (r_gap !== 0 || bus.dir !== 2'b10) begin
            errors++;
            $display("FAIL r_continuous: gaps=%0d dir=%b expected 0/10", r_gap, bus.dir);
        end
        @(negedge clk);
        vectors++;
        if (bus.dir !== 2'b00) begin
            errors++;
            $display("FAIL r_expire: got %b expected 00", bus.dir);
        end
    endtask

    task automatic test_none_cmd();
        send_byte(8'h4C, 1'b1);
        send_byte(8'h4E, 1'b1);
        vectors++;
        if (bus.dir !== 2'b00 || bus.rx_byte !== 8'h4E) begin
            errors++;
            $display("FAIL n_clear: dir=%b rx=%h expected 00/4e", bus.dir, bus.rx_byte);
        end
    endtask

    task automatic test_glitch();
        int b0 = bv_cnt;
        int f0 = fe_cnt;
        bus.get_bluetooth = 1'b0;
        repeat (40) @(negedge clk);
        bus.get_bluetooth = 1'b1;
        repeat (200) @(negedge clk);
        vectors++;
        if (bv_cnt !== b0 || fe_cnt !== f0) begin
            errors++;
            $display("FAIL glitch_pulses: bv=%0d fe=%0d expected 0/0", bv_cnt - b0, fe_cnt - f0);
        end
        vectors++;
        if (dut.u_core.state !== ST_IDLE) begin
            errors++;
            $display("FAIL glitch_state: got %0d expected %0d", dut.u_core.state, ST_IDLE);
        end
    endtask

    task automatic test_frame_err();
        int b0 = bv_cnt;
        int f0 = fe_cnt;
        send_byte(8'h51, 1'b0);
        vectors++;
        if (fe_cnt - f0 !== 1 || bv_cnt !== b0) begin
            errors++;
            $display("FAIL ferr_pulses: fe=%0d bv=%0d expected 1/0", fe_cnt - f0, bv_cnt - b0);
        end
        vectors++;
        if (bus.state_choice !== 3'b000) begin
            errors++;
            $display("FAIL ferr_sc: got %b expected 000", bus.state_choice);
        end
        send_byte(8'h51, 1'b1);
        vectors++;
        if (bus.state_choice !== 3'b101 || fe_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_recover: sc=%b fe=%0d expected 101/1", bus.state_choice, fe_cnt - f0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'h4C;
        int b0;
        send_byte(8'h52, 1'b1);
        send_byte(8'h53, 1'b1);
        b0 = bv_cnt;
        bus.get_bluetooth = 1'b1;
        repeat (40) @(negedge clk);
        bus.get_bluetooth = 1'b0;
        repeat (160) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.get_bluetooth = b[i];
            repeat (160) @(negedge clk);
        end
        bus.get_bluetooth = b[4];
        repeat (80) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.dir !== 2'b00 || bus.state_choice !== 3'b000 || bus.rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL midrst_levels: dir=%b sc=%b rx=%h expected 00/000/00", bus.dir, bus.state_choice, bus.rx_byte);
        end
        bus.get_bluetooth = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if (bv_cnt !== b0) begin
            errors++;
            $display("FAIL midrst_partial: got %0d pulses expected 0", bv_cnt - b0);
        end
        send_byte(8'h4C, 1'b1);
        vectors++;
        if (bv_cnt - b0 !== 1 || bus.rx_byte !== 8'h4C || bus.dir !== 2'b01) begin
            errors++;
            $display("FAIL midrst_recover: pulses=%0d rx=%h dir=%b expected 1/4c/01", bv_cnt - b0, bus.rx_byte, bus.dir);
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_menu();
        test_back_to_back_r();
        test_none_cmd();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
